// File: rtl/serial_tx_arbiter.sv
// Purpose: two-requester round-robin arbiter that serialises the winning byte as a UART-style frame on tx.
// Latency: grant pulse and start bit both appear in the cycle after the accepting edge; frame is 10*CLKS_PER_BIT cycles (11* with parity).
// Backpressure: requests are level-held until granted; while a frame is in flight requests are ignored, not queued.
//
// Ports: clk/rst_n (async active-low); req0/data0, req1/data1 requester inputs; gnt0/gnt1 capture pulses;
//        tx serial line (idle high, registered); busy during frame; owner of current/last frame; done end-of-frame pulse.
// Optional feature: define PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_tx_arbiter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       tx,
    output logic       busy,
    output logic       owner,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [2:0]      bit_q, bit_n;
    logic [7:0]      byte_q, byte_n;
    logic            last_q, last_n;
    logic            owner_n, gnt0_n, gnt1_n, done_n, tx_n, busy_n;
    logic            tick;
    logic            win;

    // The divider wraps exactly when the current state's bit period ends.
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_n = state_q;
        cnt_n   = '0;
        bit_n   = bit_q;
        byte_n  = byte_q;
        last_n  = last_q;
        owner_n = owner;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        done_n  = 1'b0;
        win     = 1'b0;
        if (state_q != IDLE) begin
            cnt_n = tick ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that lost last time goes next.
                    win     = (req0 && req1) ? ~last_q : req1;
                    byte_n  = win ? data1 : data0;
                    owner_n = win;
                    last_n  = win;
                    gnt0_n  = ~win;
                    gnt1_n  = win;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
`ifdef PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_q + 3'd1;
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (tick) state_n = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered, so it is derived from the state being entered.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = byte_n[bit_n];
`ifdef PARITY_EN
            PARITY:  tx_n = ^byte_n;
`endif
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 8'd0;
            last_q  <= 1'b1;
            owner   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            byte_q  <= byte_n;
            last_q  <= last_n;
            owner   <= owner_n;
            gnt0    <= gnt0_n;
            gnt1    <= gnt1_n;
            done    <= done_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Purpose: randomized scoreboard bench for serial_tx_arbiter against a frame-level reference model.
// Latency: model predicts the accepting edge of every frame; monitor checks the whole frame after each grant.
// Backpressure: requesters hold req until their grant, then drop it and scramble their data.
module tb_serial_tx_arbiter;

    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'd0, data1 = 8'd0;
    logic       gnt0, gnt1, tx, busy, owner, done;

    serial_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .tx(tx), .busy(busy), .owner(owner), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         who;
        logic [7:0] b;
    } exp_t;

    exp_t sbq[$];
    bit   gnt_log[$];
    int   checks = 0;
    int   errors = 0;
    bit   auto0 = 0, auto1 = 0;
    int   pct = 0;
    int   cyc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s got event expected none", name);
    endtask

    // Expected tx waveform: one level per CPB cycles -- start 0, LSB-first data, optional parity, stop 1.
    function automatic logic [63:0] exp_frame(logic [7:0] b);
        logic [63:0] v;
        int k;
        v = '0;
        for (int o = 0; o < FRAME; o++) begin
            k = o / CPB;
            if (k == 0)                    v[o] = 1'b0;
            else if (k <= 8)               v[o] = b[k-1];
            else if (NBITS == 11 && k == 9) v[o] = ^b;
            else                           v[o] = 1'b1;
        end
        return v;
    endfunction

    // Reference model: the line is either free or occupied for a known number of edges.
    // A frame plus its done cycle blocks FRAME+1 edges after the accepting edge.
    int busy_left = 0;
    bit last_win = 1;
    always @(posedge clk or negedge rst_n) begin : model
        bit w;
        if (!rst_n) begin
            busy_left = 0;
            last_win  = 1;
            sbq.delete();
        end else begin
            cyc++;
            if (busy_left == 0) begin
                if (req0 || req1) begin
                    w = (req0 && req1) ? !last_win : req1;
                    sbq.push_back('{cyc, w, w ? data1 : data0});
                    last_win  = w;
                    busy_left = FRAME;
                end
            end else begin
                busy_left--;
            end
        end
    end

    // Monitor: pop expectation on each grant, capture the frame, check it at the done cycle.
    bit          in_frame = 0;
    int          off = 0;
    exp_t        cur;
    logic [63:0] txv, bzv;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {tx, busy, gnt0, gnt1, done, owner}, 6'b100000);
            in_frame = 0;
        end else begin
            if (gnt0 || gnt1) begin
                gnt_log.push_back(gnt1);
                if (in_frame) fail("gnt_during_frame");
                if (sbq.size() == 0) begin
                    fail("spurious_gnt");
                end else begin
                    cur = sbq.pop_front();
                    chk("gnt_cycle", cyc, cur.cyc);
                    chk("gnt_pair", {gnt1, gnt0}, cur.who ? 2'b10 : 2'b01);
                    chk("owner", owner, cur.who);
                    in_frame = 1;
                    off = 0;
                    txv = '0;
                    bzv = '0;
                end
            end
            if (in_frame) begin
                if (off < FRAME) begin
                    txv[off] = tx;
                    bzv[off] = busy & ~done;
                    off++;
                end else begin
                    chk("frame_tx", txv, exp_frame(cur.b));
                    chk("frame_busy", bzv, (64'd1 << FRAME) - 64'd1);
                    chk("done_cycle", {done, busy, tx}, 3'b101);
                    in_frame = 0;
                end
            end else begin
                if (done) fail("spurious_done");
                if (tx !== 1'b1 || busy !== 1'b0) chk("idle_line", {tx, busy}, 2'b10);
            end
        end
    end

    // Requesters: drop and scramble data after the grant, optionally re-request.
    always @(negedge clk) begin
        if (gnt0 && req0) begin
            req0  = 1'b0;
            data0 = 8'($urandom);
        end else if (!req0 && auto0 && ($urandom_range(99) < pct)) begin
            req0  = 1'b1;
            data0 = 8'($urandom);
        end
        if (gnt1 && req1) begin
            req1  = 1'b0;
            data1 = 8'($urandom);
        end else if (!req1 && auto1 && ($urandom_range(99) < pct)) begin
            req1  = 1'b1;
            data1 = 8'($urandom);
        end
    end

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while ((req0 || req1 || busy || in_frame || sbq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("idle_timeout", n, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_gnt(int budget);
        int n;
        n = 0;
        while (!(gnt0 || gnt1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("gnt_timeout", n, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", {tx, busy, owner, done, gnt0, gnt1}, 6'b100000);

        // Simultaneous held requests straight after reset: strict alternation starting with 0.
        @(negedge clk);
        gnt_log.delete();
        data0 = 8'h11; data1 = 8'h22;
        req0 = 1'b1; req1 = 1'b1;
        pct = 100; auto0 = 1; auto1 = 1;
        repeat (4 * (FRAME + 1) + 2) @(negedge clk);
        auto0 = 0; auto1 = 0;
        wait_idle(1000);
        if (gnt_log.size() >= 4)
            chk("rr_order", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 4'b0101);
        else
            chk("rr_count", gnt_log.size(), 4);

        // Single requester, known byte.
        req0 = 1'b1; data0 = 8'hA5;
        wait_idle(500);

        // Late request from requester 1 during requester 0's frame.
        req0 = 1'b1; data0 = 8'h3C;
        wait_gnt(50);
        repeat (10) @(negedge clk);
        req1 = 1'b1; data1 = 8'h5A;
        wait_idle(500);

        // Reset mid-frame aborts immediately; a fresh request is then served normally.
        req0 = 1'b1; data0 = 8'hC3;
        wait_gnt(50);
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_abort", {tx, busy, done}, 3'b100);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        req0 = 1'b1; data0 = 8'h07;
        wait_idle(500);

        // Random traffic.
        pct = 30; auto0 = 1; auto1 = 1;
        repeat (3000) @(negedge clk);
        auto0 = 0; auto1 = 0;
        wait_idle(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clk cycles per serial bit; legal range 2..256.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req0  input  1  requester 0 frame request, level, held until gnt0.
REQ-005 Port: data0  input  8  requester 0 byte; valid while req0 is high.
REQ-006 Port: req1  input  1  requester 1 frame request, level, held until gnt1.
REQ-007 Port: data1  input  8  requester 1 byte; valid while req1 is high.
REQ-008 Port: gnt0  output  1  one-cycle pulse: data0 captured.
REQ-009 Port: gnt1  output  1  one-cycle pulse: data1 captured.
REQ-010 Port: tx  output  1  serial line, idle high, registered.
REQ-011 Port: busy  output  1  high while a frame is on tx.
REQ-012 Port: owner  output  1  index of the requester owning the current or last frame.
REQ-013 Port: done  output  1  one-cycle pulse at frame end.

Function
REQ-014 FSM states: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP; each non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a cycle divider that reloads on every state change.
REQ-015 IDLE: on an edge with req0|req1 high, the winner's byte is latched, owner is updated, FSM -> START, and the winner's gnt is high for the following cycle only.
REQ-016 Arbitration: round-robin; on a tie the requester that did not win last time wins; last-winner resets to 1, so req0 wins the first tie.
REQ-017 A single request wins regardless of history; requests while busy are ignored (no gnt) and are not queued.
REQ-018 tx: START drives 0; DATA drives the latched byte LSB first; PARITY drives the even-parity bit; STOP drives 1; IDLE drives 1.
REQ-019 DATA uses a 3-bit bit index: reset to 0 on entry to DATA, incremented per bit, and leaving DATA on the bit period in which it equals 7.
REQ-020 Latency: tx falls in the cycle after the accepting edge, i.e. coincident with gnt.
REQ-021 busy is high from the gnt cycle through the last STOP cycle.
REQ-022 done: the edge ending STOP returns the FSM to IDLE and asserts done for exactly that one IDLE cycle.
REQ-023 Back-to-back: a held request is accepted at the edge ending the done cycle, giving a minimum of 1 tx-high idle cycle between frames.
REQ-024 Frame length: 10*CLKS_PER_BIT cycles without parity and 11*CLKS_PER_BIT cycles with parity.
REQ-025 Changes to data0/data1 after gnt do not affect the frame in flight.

Reset
REQ-026 While rst_n is low, asynchronously: tx=1, busy=0, gnt0=gnt1=0, done=0, owner=0, FSM=IDLE, divider=0, bit index=0, last-winner=1.
REQ-027 Reset mid-frame aborts the frame immediately (tx high); no done is issued and the frame is not resumed.
REQ-028 The first possible grant is at the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro PARITY_EN: when defined, the PARITY state is inserted between DATA and STOP carrying the even-parity bit (XOR of the 8 data bits).
REQ-030 Without PARITY_EN, DATA goes directly to STOP and no parity logic is present.

Verification
REQ-031 CLKS_PER_BIT=4, req0=1 with data0=0xA5 -> gnt0 pulses once; tx sequence per 4 cycles: 0, 1,0,1,0,0,1,0,1, 1; done 40 cycles after gnt0; owner=0.
REQ-032 req0 and req1 rise together and both are held, data0=0x11, data1=0x22 -> frames granted in the order 0,1,0,1; each gap between frames is exactly 1 idle cycle.
REQ-033 req1 is asserted mid-frame of requester 0 -> no gnt1 until after done; then gnt1 is granted and owner=1.
REQ-034 rst_n is pulsed low at cycle 17 of a frame -> tx=1 and busy=0 within the same cycle, no done; a new req0 is granted normally afterwards.
REQ-035 PARITY_EN defined, data0=0x07 -> parity bit 1 and frame length 44 cycles; data0=0xA5 -> parity bit 0.
REQ-036 CLKS_PER_BIT=2, data0=0xFF -> tx low for 2 cycles, then high for 18 cycles, and done after 20 cycles.
